// File: rtl/aximm_mem_ctrl_pkg.sv
// Shared response codes and FSM state types for the AXI-MM memory front-end.
package aximm_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_ISSUE
    } rd_state_t;

endpackage

// File: rtl/aximm_mem_ctrl_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push is accepted while full if a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [CNTW-1:0]  cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CNTW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/aximm_mem_ctrl.sv
// AXI-MM slave front-end for the 2-cycle-latency memory stage: INCR bursts on
// both channels, read data buffered in a credit-guarded response FIFO.
module aximm_mem_ctrl #(
    parameter int DATAW     = 32,
    parameter int DEPTH     = 512,
    parameter int ADDRW     = $clog2(DEPTH),
    parameter int AXI_ADDRW = 32,
    parameter int IDW       = 4,
    parameter int RFIFO_D   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [AXI_ADDRW-1:0] awaddr,
    input  logic [IDW-1:0]       awid,
    input  logic [7:0]           awlen,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [DATAW-1:0]     wdata,
    input  logic                 wlast,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [IDW-1:0]       bid,
    output logic [1:0]           bresp,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [AXI_ADDRW-1:0] araddr,
    input  logic [IDW-1:0]       arid,
    input  logic [7:0]           arlen,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DATAW-1:0]     rdata,
    output logic [IDW-1:0]       rid,
    output logic                 rlast,
    output logic [1:0]           rresp,
    output logic [ADDRW-1:0]     mem_waddr,
    output logic                 mem_wen,
    output logic [DATAW-1:0]     mem_wdata,
    output logic [ADDRW-1:0]     mem_raddr,
    input  logic [DATAW-1:0]     mem_rdata
);

    import aximm_mem_pkg::*;

    localparam int BSHIFT = $clog2(DATAW / 8);
    localparam int FW     = DATAW + IDW + 1;
    localparam int CNTW   = $clog2(RFIFO_D + 1);
    localparam int CRW    = $clog2(RFIFO_D + 3);

    function automatic logic [ADDRW-1:0] next_addr(input logic [ADDRW-1:0] a);
        return (a == ADDRW'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // Only the word-address field of the byte addresses is meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    // ---------------- write channel ----------------
    wr_state_t        wr_state, wr_state_nx;
    logic [ADDRW-1:0] wr_addr;
    logic [IDW-1:0]   wr_id;
    logic [7:0]       wr_len;
    logic [7:0]       wr_cnt;
    logic             wr_err;
    logic             wr_last_beat;

    assign wr_last_beat = (wr_cnt == wr_len);

    always_comb begin
        wr_state_nx = wr_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        bresp       = RESP_OKAY;
        mem_wen     = 1'b0;
        mem_waddr   = wr_addr;
        mem_wdata   = wdata;
        case (wr_state)
            W_IDLE: begin
                awready = !rst;
                if (awvalid && !rst) wr_state_nx = W_DATA;
            end
            W_DATA: begin
                wready = !rst;
                if (wvalid && !rst) begin
                    mem_wen = 1'b1;
                    if (wr_last_beat) wr_state_nx = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = wr_err ? RESP_SLVERR : RESP_OKAY;
                if (bready) wr_state_nx = W_IDLE;
            end
            default: wr_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_addr  <= '0;
            wr_id    <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
        end else begin
            wr_state <= wr_state_nx;
            if (awvalid && awready) begin
                wr_addr <= awaddr[ADDRW+BSHIFT-1:BSHIFT];
                wr_id   <= awid;
                wr_len  <= awlen;
                wr_cnt  <= '0;
                wr_err  <= 1'b0;
            end
            if (wvalid && wready) begin
                wr_addr <= next_addr(wr_addr);
                wr_cnt  <= wr_cnt + 1'b1;
                if (wlast != wr_last_beat) wr_err <= 1'b1;
            end
        end
    end

    assign bid = wr_id;

    // ---------------- read channel ----------------
    rd_state_t        rd_state, rd_state_nx;
    logic [ADDRW-1:0] rd_addr;
    logic [IDW-1:0]   rd_id;
    logic [7:0]       rd_len;
    logic [7:0]       rd_cnt;
    logic             issue;
    logic             credit_ok;
    logic             s1_v, s2_v;
    logic [IDW-1:0]   s1_id, s2_id;
    logic             s1_last, s2_last;
    logic [CNTW-1:0]  fifo_count;
    logic [CRW-1:0]   credit_used;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_out;

    // Reads in the memory pipe already own a FIFO slot, so R backpressure can never overflow it.
    assign credit_used = CRW'(fifo_count) + CRW'(s1_v) + CRW'(s2_v);
    assign credit_ok   = (credit_used < CRW'(RFIFO_D));

    always_comb begin
        rd_state_nx = rd_state;
        arready     = 1'b0;
        issue       = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = !rst;
                if (arvalid && !rst) rd_state_nx = R_ISSUE;
            end
            R_ISSUE: begin
                issue = credit_ok;
                if (credit_ok && (rd_cnt == rd_len)) rd_state_nx = R_IDLE;
            end
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_addr  <= '0;
            rd_id    <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_id    <= '0;
            s2_id    <= '0;
            s1_last  <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            rd_state <= rd_state_nx;
            if (arvalid && arready) begin
                rd_addr <= araddr[ADDRW+BSHIFT-1:BSHIFT];
                rd_id   <= arid;
                rd_len  <= arlen;
                rd_cnt  <= '0;
            end
            if (issue) begin
                rd_addr <= next_addr(rd_addr);
                rd_cnt  <= rd_cnt + 1'b1;
            end
            s1_v    <= issue;
            s1_id   <= rd_id;
            s1_last <= (rd_cnt == rd_len);
            s2_v    <= s1_v;
            s2_id   <= s1_id;
            s2_last <= s1_last;
        end
    end

    assign mem_raddr = rd_addr;

    sync_fifo #(
        .WIDTH(FW),
        .DEPTH(RFIFO_D)
    ) u_rfifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s2_v),
        .push_data({mem_rdata, s2_id, s2_last}),
        .pop      (rvalid && rready),
        .pop_data (fifo_out),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign rvalid                = !fifo_empty;
    assign {rdata, rid, rlast}   = fifo_out;
    assign rresp                 = RESP_OKAY;

endmodule

// File: tb/tb_aximm_mem_ctrl.sv
// Self-checking bench for aximm_mem_ctrl: a behavioural 2-cycle memory, a word-array
// reference of expected contents, table vectors, corner-case sequences and random bursts.
module tb_aximm_mem_ctrl;

    localparam int DATAW   = 32;
    localparam int DEPTH   = 512;
    localparam int ADDRW   = 9;
    localparam int IDW     = 4;
    localparam int RFIFO_D = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0]       awaddr, araddr;
    logic [IDW-1:0]    awid, bid, arid, rid;
    logic [7:0]        awlen, arlen;
    logic [DATAW-1:0]  wdata, rdata;
    logic [1:0]        bresp, rresp;
    logic              arvalid, arready, rvalid, rready, rlast;
    logic [ADDRW-1:0]  mem_waddr, mem_raddr;
    logic              mem_wen;
    logic [DATAW-1:0]  mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aximm_mem_ctrl #(
        .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .AXI_ADDRW(32), .IDW(IDW), .RFIFO_D(RFIFO_D)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rlast(rlast), .rresp(rresp),
        .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    // Memory stage: write at the edge, registered raddr, registered rdata (read at t valid at t+2).
    logic [DATAW-1:0] mem_arr [DEPTH];
    logic [ADDRW-1:0] raddr_q;
    always @(posedge clk) begin
        if (mem_wen) mem_arr[mem_waddr] <= mem_wdata;
        raddr_q   <= mem_raddr;
        mem_rdata <= mem_arr[raddr_q];
    end

    logic [DATAW-1:0] ref_mem [DEPTH];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic do_write(input int unsigned word, input int unsigned len, input logic [3:0] id,
                            input int bad, input logic [31:0] seed, input bit rnd,
                            input logic [1:0] exp_resp, input string tag);
        logic [31:0] d [256];
        logic [31:0] a;
        int t;
        for (int i = 0; i <= int'(len); i++) d[i] = rnd ? $urandom : seed + 32'(i);
        @(posedge clk); #1;
        a = $urandom;
        a[10:2] = 9'(word);
        awaddr = a; awid = id; awlen = 8'(len); awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin @(negedge clk); t++; end
        chk({tag, "_awready"}, 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            int w;
            w = int'((word + 32'(i)) % DEPTH);
            wvalid = 1'b1; wdata = d[i];
            wlast  = (i == int'(len)) ^ (i == bad);
            t = 0;
            @(negedge clk);
            while (!wready && t < 50) begin @(negedge clk); t++; end
            chk({tag, "_wready"}, 64'(wready), 64'd1);
            chk({tag, "_mem_wen"}, 64'(mem_wen), 64'd1);
            chk({tag, "_mem_waddr"}, 64'(mem_waddr), 64'(w));
            chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(d[i]));
            ref_mem[w] = d[i];
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        @(negedge clk);
        chk({tag, "_mem_wen_off"}, 64'(mem_wen), 64'd0);
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        chk({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        chk({tag, "_bid"}, 64'(bid), 64'(id));
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    // mode 0: rready high; 1: random rready; 2: rready low for 'stall' cycles then high
    task automatic do_read(input int unsigned word, input int unsigned len, input logic [3:0] id,
                           input int mode, input int stall, input bit chk_lat, input string tag);
        logic [31:0] a;
        int t, beat, ar_cyc;
        bit seen;
        @(posedge clk); #1;
        a = $urandom;
        a[10:2] = 9'(word);
        araddr = a; arid = id; arlen = 8'(len); arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        chk({tag, "_arready"}, 64'(arready), 64'd1);
        ar_cyc = cyc;
        @(posedge clk); #1;
        arvalid = 1'b0;
        beat = 0; t = 0; seen = 1'b0;
        while (beat <= int'(len) && t < 2000) begin
            case (mode)
                1:       rready = 1'($urandom_range(0, 1));
                2:       rready = (t >= stall);
                default: rready = 1'b1;
            endcase
            @(negedge clk);
            if (!seen && rvalid) begin
                seen = 1'b1;
                // AR accepted at the edge closing ar_cyc; rvalid three edges later
                if (chk_lat) chk({tag, "_latency"}, 64'(cyc - ar_cyc), 64'd4);
            end
            if (mode == 2 && t == stall - 1) begin
                chk({tag, "_stall_rvalid"}, 64'(rvalid), 64'd1);
                chk({tag, "_stall_fifo_count"}, 64'(dut.fifo_count), 64'(RFIFO_D));
            end
            if (rvalid && rready) begin
                chk({tag, "_rdata"}, 64'(rdata), 64'(ref_mem[int'((word + 32'(beat)) % DEPTH)]));
                chk({tag, "_rid"}, 64'(rid), 64'(id));
                chk({tag, "_rlast"}, 64'(rlast), 64'(beat == int'(len)));
                chk({tag, "_rresp"}, 64'(rresp), 64'd0);
                beat++;
            end
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_all_beats"}, 64'(beat), 64'(len + 1));
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        int unsigned word;
        int unsigned len;
        logic [3:0]  id;
        int          bad;
        logic [31:0] seed;
        logic [1:0]  exp_resp;
        bit          chk_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0;
        wvalid = 0; wdata = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; rready = 0;

        vecs[0] = '{1'b1, 4,   0, 4'd3, -1, 32'hDEADBEEF, 2'b00, 1'b0};
        vecs[1] = '{1'b0, 4,   0, 4'd5, -1, 32'h0,        2'b00, 1'b1};
        vecs[2] = '{1'b1, 510, 3, 4'd1, -1, 32'd1,        2'b00, 1'b0};
        vecs[3] = '{1'b0, 510, 3, 4'd2, -1, 32'h0,        2'b00, 1'b0};
        vecs[4] = '{1'b1, 20,  1, 4'd7, 0,  32'h55,       2'b10, 1'b0};
        vecs[5] = '{1'b0, 20,  1, 4'd8, -1, 32'h0,        2'b00, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_awready", 64'(awready), 64'd0);
        chk("reset_arready", 64'(arready), 64'd0);
        chk("reset_wready",  64'(wready),  64'd0);
        chk("reset_bvalid",  64'(bvalid),  64'd0);
        chk("reset_rvalid",  64'(rvalid),  64'd0);
        chk("reset_mem_wen", 64'(mem_wen), 64'd0);
        chk("reset_bresp",   64'(bresp),   64'd0);
        chk("reset_rresp",   64'(rresp),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].wr)
                do_write(vecs[v].word, vecs[v].len, vecs[v].id, vecs[v].bad, vecs[v].seed,
                         1'b0, vecs[v].exp_resp, $sformatf("vec%0d", v));
            else
                do_read(vecs[v].word, vecs[v].len, vecs[v].id, 0, 0, vecs[v].chk_lat,
                        $sformatf("vec%0d", v));
        end

        // Long read with R stalled: FIFO must fill to depth and hold every beat.
        do_write(200, 15, 4'd2, -1, 32'h0, 1'b1, 2'b00, "stall_fill");
        do_read(200, 15, 4'd11, 2, 20, 1'b0, "stall");

        // Write and read of the same word land in the same cycle.
        do_write(7, 0, 4'd1, -1, 32'h11, 1'b0, 2'b00, "fwd_pre");
        fork
            do_write(7, 0, 4'd4, -1, 32'hA5, 1'b0, 2'b00, "fwd_w");
            do_read(7, 0, 4'd6, 0, 0, 1'b0, "fwd_r");
        join

        // Reset in the middle of a read burst.
        do_write(300, 7, 4'd3, -1, 32'h0, 1'b1, 2'b00, "rst_fill");
        @(posedge clk); #1;
        araddr = 32'(300 * 4); arid = 4'd9; arlen = 8'd7; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        chk("rst_ar_accept", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_arready_low", 64'(arready), 64'd0);
        chk("rst_awready_low", 64'(awready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rvalid_cleared", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_stale_rvalid", 64'(rvalid), 64'd0);
        do_write(301, 2, 4'd5, -1, 32'h0, 1'b1, 2'b00, "post_rst_w");
        do_read(301, 2, 4'd12, 0, 0, 1'b1, "post_rst_r");

        // Random bursts; reads target words just written so the reference is defined.
        for (int n = 0; n < 25; n++) begin
            int unsigned w, l, rl;
            int bad;
            w   = $urandom_range(0, DEPTH - 1);
            l   = $urandom_range(0, 7);
            rl  = $urandom_range(0, int'(l));
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l)) : -1;
            do_write(w, l, 4'($urandom), bad, 32'h0, 1'b1, (bad >= 0) ? 2'b10 : 2'b00,
                     $sformatf("rnd%0d_w", n));
            do_read(w, rl, 4'($urandom), 1, 0, 1'b0, $sformatf("rnd%0d_r", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
